operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Issue stage directly upstream of the 16-bit ALU. Accepts one 16-bit instruction per cycle
//  (valid/ready), decodes it, reads two operands from an internal 8x16 register file and
//  presents a, b and alu_op to the ALU through an output pipeline register.
//  Write-back port updates the register file. A busy-bit scoreboard stalls on RAW hazards.
// PARAMETERS
//  DATA_W  16  operand/register width
//  NREGS   8   register count (R0 reads as zero)
//  ADDR_W  3   register index width, log2(NREGS)
//  IMM_W   6   immediate field width, sign-extended to DATA_W
// PORTS
//  clk         in   1       single clock, all state on posedge
//  rst         in   1       synchronous, active-high reset
//  instr_valid in   1       instr holds a valid instruction
//  instr       in   16      [15:13] op, [12:10] rd, [9:7] rs, [6] imm_sel, [5:3] rt / [5:0] imm6
//  instr_ready out  1       stage accepts instr this cycle
//  ex_valid    out  1       a/b/alu_op/ex_rd are valid for the ALU
//  ex_ready    in   1       ALU side consumes the current ex_* bundle
//  a           out  DATA_W  operand A = R[rs]
//  b           out  DATA_W  operand B = imm_sel ? sext(imm6) : R[rt]
//  alu_op      out  3       op field, passed through unchanged
//  ex_rd       out  ADDR_W  destination register, carried to write-back
//  wb_en       in   1       write-back strobe
//  wb_addr     in   ADDR_W  write-back register index
//  wb_data     in   DATA_W  write-back value
//  illegal     out  1       one-cycle pulse: op==3'b111 accepted and dropped
// BEHAVIOUR
//  - Reset: ex_valid=0, a=b=0, alu_op=0, ex_rd=0, illegal=0, all regs=0, all busy bits=0.
//    Reset mid-stall or mid-hold discards the held bundle; no write-back is lost beyond that cycle.
//  - Handshake: transfer when instr_valid&&instr_ready. advance = !ex_valid || ex_ready.
//    instr_ready = advance && !hazard (ready may depend on instr fields, combinational).
//    An ex_* bundle with ex_ready=0 holds stable, bit for bit, until consumed.
//  - Latency: an accepted instruction appears on ex_* the next cycle (1 cycle).
//  - Operand read: combinational read of the regfile in the accept cycle.
//    Write-through bypass: if wb_en && wb_addr==rs (or rt), the read returns wb_data.
//    R0 always reads 0, and writes to R0 are ignored.
//  - Immediate: b = {{(DATA_W-IMM_W){imm6[5]}}, imm6} when imm_sel=1. rt is then not a source.
//  - Scoreboard: busy[rd] sets on accept of a legal op with rd!=0. busy[wb_addr] clears on wb_en.
//    Set and clear of the same index in one cycle: set wins.
//    hazard = (busy[rs] && !(wb_en && wb_addr==rs)) || (!imm_sel && same test for rt).
//    The same busy test also applies to rd (WAW), so at most one write per register is outstanding.
//  - op 3'b111: accepted (consumes instr), no ex_valid, no busy set, illegal=1 for one cycle.
//  - No accept in a cycle: ex_valid falls only when ex_ready=1. The bundle never duplicates.
//  - Arithmetic: none beyond sign extension. Widths are fixed by the parameters, with no truncation.
// STRUCTURE
//  - Shared package cpu_pkg: OP_* 3-bit opcode constants (ADD 000, SUB 001, SHR 010, SHL 011,
//    NAND 100, OR 101, PASS 110, ILL 111), instr field positions, DATA_W/ADDR_W defaults.
//  - One sub-module: regfile_2r1w (NREGS x DATA_W, 2 async read ports with write-through
//    bypass, 1 sync write port, R0 hardwired to zero).
//  - Scoreboard, decode and the output register live in the top module.
// TESTING
//  1. rst=1 for 2 clk with instr_valid=1 -> ex_valid=0, instr_ready=0 during reset, all regs read 0.
//  2. wb R1=0x0005, R2=0x0003, then issue ADD rd=3 rs=1 rt=2 -> next cycle a=0x0005,
//     b=0x0003, alu_op=000, ex_rd=3, ex_valid=1, busy[3]=1.
//  3. SUB rd=4 rs=3 imm_sel=0 rt=1 right after item 2 -> instr_ready=0 until wb_en addr=3.
//     In the wb cycle it is accepted with a=wb_data (bypass).
//  4. imm_sel=1, imm6=6'b111110, rs=0 -> a=0x0000, b=0xFFFE. rt=busy is ignored, with no stall.
//  5. ex_ready=0 for 3 cycles with instr_valid=1 -> ex_* stable, instr_ready=0.
//     On ex_ready=1 the next instr is accepted in the same cycle, with no loss and no duplicate.
//  6. op=111 -> illegal pulses 1 cycle, ex_valid unchanged, no busy bit set.
//     wb_en addr=0 data=0xFFFF -> R0 still reads 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcodes and the issue-stage instruction layout.
package cpu_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NREGS   = 8;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned IMM_W   = 6;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_SHR  = 3'b010,
        OP_SHL  = 3'b011,
        OP_NAND = 3'b100,
        OP_OR   = 3'b101,
        OP_PASS = 3'b110,
        OP_ILL  = 3'b111
    } op_e;

    // [15:13] op, [12:10] rd, [9:7] rs, [6] imm_sel, [5:0] imm6 (rt aliases imm6[5:3])
    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs;
        logic              imm_sel;
        logic [IMM_W-1:0]  imm6;
    } instr_t;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Issue-stage bus: instruction in, ALU bundle out, write-back in.
interface operand_fetch_if;
    import cpu_pkg::*;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;
    logic               ex_valid;
    logic               ex_ready;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [OP_W-1:0]    alu_op;
    logic [ADDR_W-1:0]  ex_rd;
    logic               wb_en;
    logic [ADDR_W-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               illegal;

    modport master (
        output instr_valid, instr, ex_ready, wb_en, wb_addr, wb_data,
        input  instr_ready, ex_valid, a, b, alu_op, ex_rd, illegal
    );

    modport slave (
        input  instr_valid, instr, ex_ready, wb_en, wb_addr, wb_data,
        output instr_ready, ex_valid, a, b, alu_op, ex_rd, illegal
    );

endinterface

// File: rtl/regfile_2r1w.sv
// NREGS x DATA_W register file: two async read ports with write-through, one sync write, R0 = 0.
module regfile_2r1w
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra0,
    output logic [DATA_W-1:0] rd0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    // Same-cycle write data is forwarded so a reader never sees the stale value.
    assign rd0 = (ra0 == '0) ? '0 : (we && wa == ra0) ? wd : mem[ra0];
    assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : mem[ra1];

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: decode, operand read, RAW/WAW scoreboard and the output register feeding the ALU.
module operand_fetch
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    operand_fetch_if.slave bus
);

    instr_t            dec;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [NREGS-1:0]  busy;
    logic              pend_rs;
    logic              pend_rt;
    logic              pend_rd;
    logic              hazard;
    logic              advance;
    logic              accept;
    logic              legal;

    assign dec = instr_t'(bus.instr);
    assign rt  = dec.imm6[IMM_W-1:IMM_W-ADDR_W];

    regfile_2r1w u_rf (
        .clk (clk),
        .rst (rst),
        .ra0 (dec.rs),
        .rd0 (rf_a),
        .ra1 (rt),
        .rd1 (rf_b),
        .we  (bus.wb_en),
        .wa  (bus.wb_addr),
        .wd  (bus.wb_data)
    );

    // A busy register whose write-back lands this cycle is already resolved via the bypass.
    always_comb begin
        pend_rs = busy[dec.rs] && !(bus.wb_en && bus.wb_addr == dec.rs);
        pend_rt = busy[rt]     && !(bus.wb_en && bus.wb_addr == rt);
        pend_rd = busy[dec.rd] && !(bus.wb_en && bus.wb_addr == dec.rd);
        hazard  = pend_rs || (!dec.imm_sel && pend_rt) || pend_rd;
    end

    assign advance         = !bus.ex_valid || bus.ex_ready;
    assign bus.instr_ready = !rst && advance && !hazard;
    assign accept          = bus.instr_valid && bus.instr_ready;
    assign legal           = (dec.op != OP_ILL);

    // Set wins over a same-cycle clear; R0 is never tracked.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < int'(NREGS); i++) begin
                if (accept && legal && dec.rd == ADDR_W'(i))
                    busy[i] <= 1'b1;
                else if (bus.wb_en && bus.wb_addr == ADDR_W'(i))
                    busy[i] <= 1'b0;
            end
            busy[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ex_valid <= 1'b0;
            bus.a        <= '0;
            bus.b        <= '0;
            bus.alu_op   <= '0;
            bus.ex_rd    <= '0;
            bus.illegal  <= 1'b0;
        end else begin
            bus.illegal <= accept && !legal;
            if (advance) begin
                bus.ex_valid <= accept && legal;
                if (accept && legal) begin
                    bus.a      <= rf_a;
                    bus.b      <= dec.imm_sel ? sext_imm(dec.imm6) : rf_b;
                    bus.alu_op <= dec.op;
                    bus.ex_rd  <= dec.rd;
                end
            end
        end
    end

endmodule
